// File: rtl/pri_arb_pkg.sv
// rtl/pri_arb_pkg.sv - shared state encodings for the priority arbiter
package pri_arb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/pri_arb_if.sv
// rtl/pri_arb_if.sv - request/grant handshake bundle between requesters, arbiter and resource
interface pri_arb_if #(
  parameter int N = 16,
  parameter int W = $clog2(N)
);
  logic [N-1:0] i_req;
  logic [N-1:0] i_mask;
  logic         i_ack;
  logic         i_done;
  logic [N-1:0] o_pending;
  logic         o_valid;
  logic [N-1:0] o_grant;
  logic [W-1:0] o_id;
  logic         o_busy;

  modport slave (
    input  i_req, i_mask, i_ack, i_done,
    output o_pending, o_valid, o_grant, o_id, o_busy
  );

  modport master (
    output i_req, i_mask, i_ack, i_done,
    input  o_pending, o_valid, o_grant, o_id, o_busy
  );
endinterface

// File: rtl/pri_arb_pri8.sv
// rtl/pri_arb_pri8.sv - fixed-priority encoder, highest set index wins, one-hot output
module pri8 #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // Ascending scan: the last set bit seen is the highest index.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pri_arb.sv
// rtl/pri_arb.sv - pulse-latched fixed-priority arbiter with grant/ack/done handshake
import pri_arb_defs::*;

module pri_arb #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input logic      i_clk,
  input logic      i_rst,
  pri_arb_if.slave bus
);

  arb_state_t   state_q, state_d;
  logic [N-1:0] pend_q;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] id_q;
  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [N-1:0] winner;

  function automatic logic [W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | W'(i);
    end
    return idx;
  endfunction

  assign eligible = pend_q & ~bus.i_mask;

  pri8 #(.N(N)) u_pri8 (
    .req   (eligible),
    .grant (winner)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    clr     = '0;
    case (state_q)
      ARB_IDLE: begin
        if (|eligible) begin
          state_d = ARB_GRANT;
          grant_d = winner;
        end
      end
      ARB_GRANT: begin
        // Grant is frozen here; only the ack retires the pending bit.
        if (bus.i_ack) begin
          clr = grant_q;
          if (bus.i_done) begin
            state_d = ARB_IDLE;
            grant_d = '0;
          end else begin
            state_d = ARB_BUSY;
          end
        end
      end
      ARB_BUSY: begin
        if (bus.i_done) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARB_IDLE;
      pend_q  <= '0;
      grant_q <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      // Set wins over clear so a re-request in the ack cycle is not lost.
      pend_q  <= (pend_q & ~clr) | bus.i_req;
      grant_q <= grant_d;
      id_q    <= onehot_to_idx(grant_d);
    end
  end

  assign bus.o_pending = pend_q;
  assign bus.o_valid   = (state_q == ARB_GRANT);
  assign bus.o_busy    = (state_q == ARB_BUSY);
  assign bus.o_grant   = grant_q;
  assign bus.o_id      = id_q;

endmodule

// File: doc/pri_arb.md
# pri_arb

Fixed-priority request arbiter that shares one resource (e.g. a channel/storage port) among up to N requesters. Requests are pulse-latched into a pending register. The masked pending vector goes through the existing `pri8` priority encoder, where the highest index wins. The winner is then held through a grant/ack/done handshake, so the resource is granted to exactly one requester at a time. It sits between requester request lines and the resource sequencer, in the same role as an interrupt-pending/priority stage.

## Interface
- `N`, default 16: number of requesters; 2..16.
- `W`, default `$clog2(N)`: width of the winner index.

- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high; clears all state.
- `i_req`  in  N  request pulses or levels; any cycle high sets the pending bit.
- `i_mask`  in  N  1 = requester inhibited from winning; its pending bit is kept.
- `i_ack`  in  1  resource accepted the current grant.
- `i_done`  in  1  resource finished servicing the granted requester.
- `o_pending`  out  N  pending register.
- `o_valid`  out  1  a grant is offered (state GRANT).
- `o_grant`  out  N  one-hot registered winner; nonzero only in GRANT and BUSY.
- `o_id`  out  W  binary index of `o_grant`.
- `o_busy`  out  1  state BUSY.

## Operation
- Pending update each edge: `pend <= (pend & ~clr) | i_req`.
  - `clr` is the one-hot winner when the ACK transition fires, otherwise 0.
  - Set wins over clear: a bit re-requested in the ack cycle stays pending.
- Eligible vector is `pend & ~i_mask`. It feeds `pri8` combinationally; the winner is the highest eligible index.
- IDLE state:
  - `o_valid`, `o_busy` and `o_grant` are all 0.
  - If the eligible vector is nonzero, latch the `pri8` output into `o_grant` (and its index into `o_id`), then go to GRANT.
- GRANT state:
  - `o_valid` = 1; `o_grant` is frozen. Later higher-priority requests and mask changes do not revoke or change it.
  - On `i_ack`: clear the winner's pending bit.
    - If `i_done` is also high, go to IDLE.
    - Otherwise go to BUSY.
  - `i_done` without `i_ack` is ignored.
- BUSY state:
  - `o_busy` = 1, `o_valid` = 0; `o_grant` is held.
  - `i_ack` is ignored.
  - On `i_done`, go to IDLE and clear `o_grant` and `o_id`.
- No preemption and no fairness: a permanently re-requesting high index can starve lower ones. This is intended, to match 2050 priority semantics.
- Reset at any point, including mid-GRANT or mid-BUSY:
  - state = IDLE; `o_pending`, `o_grant`, `o_id` = 0; `o_valid` = `o_busy` = 0.
  - Any in-flight grant is abandoned; the resource side must also be reset.
- `i_req` asserted during reset is not captured.

## Timing
- `i_req` high in cycle 0 gives pending set after edge 1, then `o_valid` and `o_grant` after edge 2. Minimum request-to-grant latency is 2 cycles.
- `i_ack` in cycle k: pending bit clears and the state leaves GRANT at edge k+1.
- `i_done` in BUSY cycle m: IDLE after edge m+1. The earliest next grant is at edge m+2. At least one IDLE cycle separates consecutive grants.
- All outputs are registered; no combinational path from any input to any output.
- Eligibility uses `i_mask` as sampled in the IDLE cycle that selects the winner.

## Structure
- Shared package/header `pri_arb_defs`: state encodings `ARB_IDLE`=2'd0, `ARB_GRANT`=2'd1, `ARB_BUSY`=2'd2. 2'd3 is illegal and recovers to IDLE.
- Sub-module: instantiate `pri8` (with `N` passed through) for winner selection. Do not duplicate the priority logic.
- One-hot to index conversion is a local function; no separate module.
- Expected size is about 150 RTL lines.

## Test plan
- Reset: assert `i_rst` asynchronously mid-cycle while in BUSY with `o_grant`=16'h0100 → all outputs 0 immediately; IDLE after release; pending empty.
- Priority: `i_req`=16'h0012 for one cycle → `o_grant`=16'h0010, `o_id`=4; after ack+done, the next grant is 16'h0002, `o_id`=1.
- Mask: pending 16'h8001 with `i_mask`=16'h8000 → grant 16'h0001; `o_pending` keeps bit 15. Clearing the mask then yields grant 16'h8000.
- No revoke: in GRANT on bit 3, raise `i_req` bit 12 → `o_grant` stays 16'h0008 through BUSY; bit 12 is granted only after `i_done` plus one IDLE cycle.
- Set-wins: `i_req` bit 5 high in the same cycle as `i_ack` for a bit-5 grant → `o_pending[5]` stays 1 and bit 5 is granted again after `i_done`.
- Combined handshake: `i_ack` and `i_done` both high in the GRANT cycle → direct to IDLE, `o_busy` never asserts.
